ccl_union_find: RTL and testbench

CCL_UNION_FIND -- requirements
Module: ccl_union_find

---
 rtl/ccl_union_find.sv | 212 +++++++++++++++++++++
 tb/tb_ccl_union_find.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ccl_union_find.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : ccl_union_find                                             |
// | Description : Streaming connected-component labeller with an in-place   |
// |               union-find equivalence table and a flattening pass.        |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module ccl_union_find #(
  parameter int LABEL_W      = 8,
  parameter int MAX_LABELS   = 255,
  parameter int CONNECTIVITY = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               en,
  input  logic               sof,
  input  logic               eof,
  input  logic [LABEL_W-1:0] A,
  input  logic [LABEL_W-1:0] B,
  input  logic [LABEL_W-1:0] C,
  input  logic [LABEL_W-1:0] D,
  input  logic [LABEL_W-1:0] data,
  output logic [LABEL_W-1:0] q,
  output logic               q_valid,
  output logic               overflow,
  output logic               busy,
  output logic               done,
  input  logic [LABEL_W-1:0] rd_addr,
  output logic [LABEL_W-1:0] rd_label
);

  localparam int               c_depth      = 2 ** LABEL_W;
  // The label counter is one bit wider than a label so that it can point one
  // past MAX_LABELS once the last allocatable label has been handed out.
  localparam logic [LABEL_W:0]   c_max_labels = (LABEL_W + 1)'(MAX_LABELS);
  localparam logic [LABEL_W:0]   c_cnt_one    = {{LABEL_W{1'b0}}, 1'b1};
  localparam logic [LABEL_W-1:0] c_idx_one    = {{(LABEL_W - 1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_LABEL   = 2'd0,
    ST_RESOLVE = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

  state_t             r_state;
  logic [LABEL_W:0]   r_num_labels;
  logic [LABEL_W-1:0] r_idx;
  logic [LABEL_W-1:0] r_q;
  logic               r_q_valid;
  logic               r_overflow;
  logic               r_busy;
  logic               r_done;
  logic [LABEL_W-1:0] r_table [c_depth];

  logic [LABEL_W-1:0]      w_a;
  logic [LABEL_W-1:0]      w_c;
  logic [3:0][LABEL_W-1:0] w_nb;
  logic [LABEL_W-1:0]      w_lo;
  logic [LABEL_W-1:0]      w_hi;
  logic                    w_any;
  logic [LABEL_W:0]        w_nl;
  logic                    w_labeling;
  logic                    w_resolving;
  logic                    w_can_alloc;
  logic [LABEL_W-1:0]      w_r1;
  logic [LABEL_W-1:0]      w_r2;
  logic [LABEL_W-1:0]      w_root_lo;
  logic [LABEL_W-1:0]      w_root_hi;
  logic [LABEL_W-1:0]      w_res_ptr;
  logic [LABEL_W-1:0]      w_res_val;
  logic                    w_res_last;
  logic                    w_new;
  logic [LABEL_W-1:0]      w_q;
  logic                    w_we;
  logic [LABEL_W-1:0]      w_waddr;
  logic [LABEL_W-1:0]      w_wdata;

  // Diagonal neighbours do not exist in 4-connectivity.
  generate
    if (CONNECTIVITY == 4) begin : g_conn4
      assign w_a = '0;
      assign w_c = '0;
    end else begin : g_conn8
      assign w_a = A;
      assign w_c = C;
    end
  endgenerate

  assign w_nb = {D, w_c, B, w_a};

  // Smallest and largest nonzero neighbour; equal values mean a plain copy.
  always_comb begin
    w_lo  = '1;
    w_hi  = '0;
    w_any = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (w_nb[k] != '0) begin
        w_any = 1'b1;
        if (w_nb[k] < w_lo) w_lo = w_nb[k];
        if (w_nb[k] > w_hi) w_hi = w_nb[k];
      end
    end
  end

  // A sof arriving with a pixel restarts the frame before that pixel is seen.
  assign w_nl        = sof ? c_cnt_one : r_num_labels;
  assign w_labeling  = en && (sof || (r_state == ST_LABEL));
  assign w_resolving = !sof && (r_state == ST_RESOLVE);
  assign w_can_alloc = (w_nl <= c_max_labels);

  assign w_r1      = r_table[w_lo];
  assign w_r2      = r_table[w_hi];
  assign w_root_lo = (w_r1 < w_r2) ? w_r1 : w_r2;
  assign w_root_hi = (w_r1 < w_r2) ? w_r2 : w_r1;

  // Ascending order guarantees table[table[i]] is already flat when i is hit.
  assign w_res_ptr  = r_table[r_idx];
  assign w_res_val  = r_table[w_res_ptr];
  assign w_res_last = (({1'b0, r_idx} + c_cnt_one) >= r_num_labels);

  // Pixel classification and the single table write port for this cycle.
  always_comb begin
    w_new   = 1'b0;
    w_q     = '0;
    w_we    = 1'b0;
    w_waddr = '0;
    w_wdata = '0;
    if (w_labeling && (data != '0)) begin
      if (!w_any) begin
        w_new = 1'b1;
        if (w_can_alloc) begin
          w_q     = w_nl[LABEL_W-1:0];
          w_we    = 1'b1;
          w_waddr = w_nl[LABEL_W-1:0];
          w_wdata = w_nl[LABEL_W-1:0];
        end else begin
          w_q = c_max_labels[LABEL_W-1:0];
        end
      end else if (w_lo == w_hi) begin
        w_q = w_r1;
      end else begin
        w_q     = w_root_lo;
        w_we    = 1'b1;
        w_waddr = w_root_hi;
        w_wdata = w_root_lo;
      end
    end else if (w_resolving && ({1'b0, r_idx} < r_num_labels)) begin
      w_we    = 1'b1;
      w_waddr = r_idx;
      w_wdata = w_res_val;
    end
  end

  // Equivalence table storage; contents are meaningful only once written.
  always_ff @(posedge clk) begin
    if (reset_n && w_we) r_table[w_waddr] <= w_wdata;
  end

  // Control state machine with registered status outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_LABEL;
      r_num_labels <= c_cnt_one;
      r_idx        <= c_idx_one;
      r_q          <= '0;
      r_q_valid    <= 1'b0;
      r_overflow   <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_q_valid <= 1'b0;
      if (sof) begin
        r_state      <= ST_LABEL;
        r_num_labels <= c_cnt_one;
        r_idx        <= c_idx_one;
        r_overflow   <= 1'b0;
        r_busy       <= 1'b0;
        r_done       <= 1'b0;
      end
      if (w_labeling) begin
        r_q       <= w_q;
        r_q_valid <= 1'b1;
        if (w_new) begin
          if (w_can_alloc) r_num_labels <= w_nl + c_cnt_one;
          else             r_overflow   <= 1'b1;
        end
        if (eof) begin
          r_state <= ST_RESOLVE;
          r_busy  <= 1'b1;
          r_idx   <= c_idx_one;
        end
      end else if (w_resolving) begin
        if (w_res_last) begin
          r_state <= ST_DONE;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
        end else begin
          r_idx <= r_idx + c_idx_one;
        end
      end
    end
  end

  assign q        = r_q;
  assign q_valid  = r_q_valid;
  assign overflow = r_overflow;
  assign busy     = r_busy;
  assign done     = r_done;
  assign rd_label = ((rd_addr == '0) || ({1'b0, rd_addr} >= r_num_labels)) ? '0 : r_table[rd_addr];

endmodule
`default_nettype wire

// File: tb/tb_ccl_union_find.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_ccl_union_find                                          |
// | Description : Self-checking bench: directed vector table on a default    |
// |               and a small (MAX_LABELS=3, 4-conn) instance, then random   |
// |               frames against a behavioural union-find model.             |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module tb_ccl_union_find;

  localparam int M_MAX = 255;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       en, sof, eof;
  logic [7:0] A, B, C, D, data, rd_addr;
  logic [7:0] q0, q1, rl0, rl1;
  logic       qv0, qv1, ov0, ov1, bz0, bz1, dn0, dn1;

  always #5 clk = ~clk;

  ccl_union_find #(.LABEL_W(8), .MAX_LABELS(255), .CONNECTIVITY(8)) dut0 (
    .clk(clk), .reset_n(reset_n), .en(en), .sof(sof), .eof(eof),
    .A(A), .B(B), .C(C), .D(D), .data(data),
    .q(q0), .q_valid(qv0), .overflow(ov0), .busy(bz0), .done(dn0),
    .rd_addr(rd_addr), .rd_label(rl0));

  ccl_union_find #(.LABEL_W(8), .MAX_LABELS(3), .CONNECTIVITY(4)) dut1 (
    .clk(clk), .reset_n(reset_n), .en(en), .sof(sof), .eof(eof),
    .A(A), .B(B), .C(C), .D(D), .data(data),
    .q(q1), .q_valid(qv1), .overflow(ov1), .busy(bz1), .done(dn1),
    .rd_addr(rd_addr), .rd_label(rl1));

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit sof, en, eof;
    int a, b, c, d, data, rd;
    int q0, q1;        // -1: not checked
    bit qv, ov1;
    int bd0, bd1;      // {busy,done}; -1: not checked
    int rd0, rd1;      // -1: not checked
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(bit s, bit e, bit f, int a, int b, int c, int d, int dt, int rd,
                              int eq0, int eq1, bit eqv, bit eov1, int ebd0, int ebd1,
                              int erd0, int erd1);
    vec_t v;
    v.sof = s; v.en = e; v.eof = f; v.a = a; v.b = b; v.c = c; v.d = d;
    v.data = dt; v.rd = rd; v.q0 = eq0; v.q1 = eq1; v.qv = eqv; v.ov1 = eov1;
    v.bd0 = ebd0; v.bd1 = ebd1; v.rd0 = erd0; v.rd1 = erd1;
    return v;
  endfunction

  // ---------------- behavioural model (8-conn, MAX 255) ----------------
  int m_tbl[256];
  int m_nl;
  bit m_ovf;
  int m_st;    // 0 labelling, 1 resolving, 2 done
  int m_left;
  int m_q;
  bit m_qv;

  function automatic int root_of(int i);
    int j = i;
    for (int g = 0; g < 256 && m_tbl[j] != j; g++) j = m_tbl[j];
    return j;
  endfunction

  task automatic model_step();
    int nb[4];
    int lo, hi, r1, r2, pix;
    bit any;
    m_qv = 1'b0;
    if (sof) begin m_st = 0; m_nl = 1; m_ovf = 1'b0; end
    if (m_st == 0) begin
      if (en) begin
        nb[0] = A; nb[1] = B; nb[2] = C; nb[3] = D;
        any = 1'b0; lo = 1000; hi = 0;
        foreach (nb[k]) if (nb[k] != 0) begin
          any = 1'b1;
          if (nb[k] < lo) lo = nb[k];
          if (nb[k] > hi) hi = nb[k];
        end
        if (data == 0) pix = 0;
        else if (!any) begin
          if (m_nl <= M_MAX) begin pix = m_nl; m_tbl[m_nl] = m_nl; m_nl++; end
          else begin pix = M_MAX; m_ovf = 1'b1; end
        end else if (lo == hi) pix = m_tbl[lo];
        else begin
          r1 = m_tbl[lo]; r2 = m_tbl[hi];
          pix = (r1 < r2) ? r1 : r2;
          m_tbl[(r1 < r2) ? r2 : r1] = pix;
        end
        m_q = pix; m_qv = 1'b1;
        if (eof) begin m_st = 1; m_left = (m_nl > 1) ? m_nl - 1 : 1; end
      end
    end else if (m_st == 1) begin
      m_left--;
      if (m_left == 0) begin
        for (int i = 1; i < m_nl; i++) m_tbl[i] = root_of(i);
        m_st = 2;
      end
    end
  endtask

  task automatic compare_model();
    int exp_rd;
    exp_rd = (rd_addr == 0 || int'(rd_addr) >= m_nl) ? 0 : m_tbl[rd_addr];
    check("rnd q_valid", qv0, m_qv);
    if (m_qv) check("rnd q", q0, m_q);
    check("rnd overflow", ov0, m_ovf);
    check("rnd busy", bz0, m_st == 1);
    check("rnd done", dn0, m_st == 2);
    if (m_st != 1) check("rnd rd_label", rl0, exp_rd);
  endtask

  function automatic logic [7:0] pick(bit s);
    if (s || m_nl < 2 || $urandom_range(0, 1) == 0) return 8'd0;
    return 8'($urandom_range(1, m_nl - 1));
  endfunction

  task automatic rand_cycle(input bit s, input bit last);
    sof  = s;
    en   = last ? 1'b1 : ($urandom_range(0, 3) != 0);
    data = ($urandom_range(0, 3) != 0) ? 8'($urandom_range(1, 255)) : 8'd0;
    A = pick(s); B = pick(s); C = pick(s); D = pick(s);
    eof  = last || (!en && $urandom_range(0, 7) == 0);
    rd_addr = 8'($urandom_range(0, 70));
    model_step();
    tick();
    compare_model();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    // sof en eof  A B C D dt rd   q0 q1 qv ov1 bd0 bd1 rd0 rd1
    vt.push_back(mk(1,0,0, 0,0,0,0,0, 0,   0, 0,0,0, 0,0,  0, 0));
    vt.push_back(mk(0,1,0, 0,0,0,0,1, 1,   1, 1,1,0, 0,0,  1, 1));
    vt.push_back(mk(0,1,0, 0,0,0,0,1, 2,   2, 2,1,0, 0,0,  2, 2));
    vt.push_back(mk(0,1,0, 0,0,0,0,1, 3,   3, 3,1,0, 0,0,  3, 3));
    vt.push_back(mk(0,1,0, 0,3,0,2,1, 3,   2, 2,1,0, 0,0,  2, 2));
    vt.push_back(mk(0,1,0, 0,2,0,1,1, 2,   1, 1,1,0, 0,0,  1, 1));
    vt.push_back(mk(0,1,0, 3,3,3,3,1, 3,   2, 2,1,0, 0,0,  2, 2));
    vt.push_back(mk(0,1,0, 1,3,2,3,1, 2,   1, 2,1,0, 0,0,  1, 1));
    vt.push_back(mk(0,1,0, 0,0,0,0,1, 4,   4, 3,1,1, 0,0,  4, 0));
    vt.push_back(mk(0,1,1, 0,0,0,0,0, 3,   0, 0,1,1, 2,2, -1,-1));
    vt.push_back(mk(0,0,0, 0,0,0,0,0, 3,  -1,-1,0,1, 2,2, -1,-1));
    vt.push_back(mk(0,0,0, 0,0,0,0,0, 3,  -1,-1,0,1, 2,2, -1,-1));
    vt.push_back(mk(0,0,0, 0,0,0,0,0, 3,  -1,-1,0,1, 2,1, -1, 1));
    vt.push_back(mk(0,1,0, 0,0,0,0,1, 3,  -1,-1,0,1, 1,1,  1, 1));
    vt.push_back(mk(0,0,0, 0,0,0,0,0, 2,  -1,-1,0,1, 1,1,  1, 1));
    vt.push_back(mk(0,0,0, 0,0,0,0,0, 1,  -1,-1,0,1, 1,1,  1, 1));
    vt.push_back(mk(0,0,0, 0,0,0,0,0, 4,  -1,-1,0,1, 1,1,  4, 0));
    vt.push_back(mk(0,0,0, 0,0,0,0,0, 0,  -1,-1,0,1, 1,1,  0, 0));
    vt.push_back(mk(1,1,0, 0,0,0,0,1, 1,   1, 1,1,0, 0,0,  1, 1));
    vt.push_back(mk(0,1,0, 5,0,6,0,1, 2,  -1, 2,1,0, 0,0, -1, 2));
    vt.push_back(mk(0,1,1, 0,0,0,0,0, 0,   0, 0,1,0, 2,2, -1,-1));
    vt.push_back(mk(0,0,0, 0,0,0,0,0, 0,  -1,-1,0,0, 1,2, -1,-1));
    vt.push_back(mk(1,0,0, 0,0,0,0,0, 0,  -1,-1,0,0, 0,0,  0, 0));
    vt.push_back(mk(0,1,0, 0,0,0,0,1, 1,   1, 1,1,0, 0,0,  1, 1));
    vt.push_back(mk(0,1,0, 0,0,0,0,0, 1,   0, 0,1,0, 0,0,  1, 1));
    vt.push_back(mk(1,1,1, 0,0,0,0,0, 1,   0, 0,1,0, 2,2, -1,-1));
    vt.push_back(mk(0,0,0, 0,0,0,0,0, 1,  -1,-1,0,0, 1,1,  0, 0));

    // ---- reset state ----
    reset_n = 1'b0; en = 1'b0; sof = 1'b0; eof = 1'b0;
    A = '0; B = '0; C = '0; D = '0; data = '0; rd_addr = 8'd1;
    #12;
    check("reset q", q0, 0);
    check("reset q_valid", qv0, 0);
    check("reset overflow", ov1, 0);
    check("reset busy", bz0, 0);
    check("reset done", dn1, 0);
    check("reset rd_label", rl0, 0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();

    // ---- directed vectors ----
    for (int i = 0; i < vt.size(); i++) begin
      v = vt[i];
      sof = v.sof; en = v.en; eof = v.eof;
      A = 8'(v.a); B = 8'(v.b); C = 8'(v.c); D = 8'(v.d);
      data = 8'(v.data); rd_addr = 8'(v.rd);
      tick();
      if (v.q0 >= 0) check($sformatf("vec%0d q(8c)", i), q0, v.q0);
      if (v.q1 >= 0) check($sformatf("vec%0d q(4c)", i), q1, v.q1);
      check($sformatf("vec%0d q_valid(8c)", i), qv0, v.qv);
      check($sformatf("vec%0d q_valid(4c)", i), qv1, v.qv);
      check($sformatf("vec%0d overflow(4c)", i), ov1, v.ov1);
      if (v.bd0 >= 0) check($sformatf("vec%0d busy/done(8c)", i), {bz0, dn0}, v.bd0);
      check($sformatf("vec%0d busy/done(4c)", i), {bz1, dn1}, v.bd1);
      if (v.rd0 >= 0) check($sformatf("vec%0d rd_label(8c)", i), rl0, v.rd0);
      if (v.rd1 >= 0) check($sformatf("vec%0d rd_label(4c)", i), rl1, v.rd1);
    end

    // ---- random frames against the model ----
    m_st = 0; m_nl = 1; m_ovf = 1'b0;
    for (int f = 0; f < 8; f++) begin
      int npix;
      int abort_at;
      npix = $urandom_range(10, 80);
      abort_at = (f % 3 == 1) ? $urandom_range(0, 4) : -1;
      for (int p = 0; p < npix; p++) rand_cycle(p == 0, p == npix - 1);
      for (int k = 0; k < 300; k++) begin
        if (m_st == 2) break;
        rand_cycle(k == abort_at, 1'b0);
        if (k == abort_at) break;
      end
      for (int k = 0; k < 3; k++) rand_cycle(1'b0, 1'b0);
    end

    // ---- reset asserted mid-frame ----
    sof = 1'b1; en = 1'b1; eof = 1'b0; data = 8'd1;
    A = '0; B = '0; C = '0; D = '0; rd_addr = 8'd1;
    tick();
    sof = 1'b0;
    tick(); tick(); tick();
    check("prereset q(4c)", q1, 3);
    check("prereset overflow(4c)", ov1, 1);
    en = 1'b0;
    #3 reset_n = 1'b0;
    #1;
    check("midreset q", q0, 0);
    check("midreset q_valid", qv0, 0);
    check("midreset overflow(4c)", ov1, 0);
    check("midreset rd_label", rl0, 0);
    #1 reset_n = 1'b1;
    @(posedge clk);
    #1;
    en = 1'b1; data = 8'd1;
    tick();
    check("postreset q(8c)", q0, 1);
    check("postreset q(4c)", q1, 1);
    check("postreset q_valid", qv0, 1);
    en = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
